// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider on the falling edge of the 50 MHz board clock.
// Each channel produces a square wave or a one-cycle tick from a runtime divisor.
module multi_clock_divider #(
  parameter int                CHANNELS    = 4,
  parameter int                WIDTH       = 26,
  parameter logic [WIDTH-1:0]  DEFAULT_DIV = WIDTH'('hC350)
) (
  input  logic                clock_50MHZ,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] mode,
  input  logic                sync_clear,
  input  logic                load_valid,
  input  logic [3:0]          load_ch,
  input  logic [WIDTH-1:0]    load_value,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] shadow_div;
    logic             clk_q;
    logic             tick_q;
    logic             load_hit;
    logic             terminal;

    // Out-of-range channel indices never match any channel, so they are dropped.
    assign load_hit = load_valid && (load_ch == 4'(i));
    assign terminal = (counter == active_div);

    always_ff @(negedge clock_50MHZ or negedge reset_n) begin
      if (!reset_n) begin
        counter    <= '0;
        active_div <= DEFAULT_DIV;
        shadow_div <= DEFAULT_DIV;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else if (sync_clear) begin
        counter <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        if (load_hit) begin
          shadow_div <= load_value;
          if (!enable[i]) active_div <= load_value;
        end
      end else if (!enable[i]) begin
        counter <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        if (load_hit) begin
          active_div <= load_value;
          shadow_div <= load_value;
        end
      end else if (terminal) begin
        counter <= '0;
        tick_q  <= 1'b1;
        clk_q   <= mode[i] ? 1'b1 : ~clk_q;
        // Divisor swaps only at the period boundary so the running period is never cut short.
        if (load_hit) begin
          active_div <= load_value;
          shadow_div <= load_value;
        end else begin
          active_div <= shadow_div;
        end
      end else begin
        counter <= counter + WIDTH'(1);
        tick_q  <= 1'b0;
        clk_q   <= mode[i] ? 1'b0 : clk_q;
        if (load_hit) shadow_div <= load_value;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider: expected tick intervals are queued
// when stimulus is applied and popped when the channel ticks.
module tb_multi_clock_divider;
  localparam int CHANNELS = 4;
  localparam int WIDTH    = 8;

  logic                clock_50MHZ;
  logic                reset_n;
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] mode;
  logic                sync_clear;
  logic                load_valid;
  logic [3:0]          load_ch;
  logic [WIDTH-1:0]    load_value;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  multi_clock_divider #(
    .CHANNELS(CHANNELS),
    .WIDTH(WIDTH),
    .DEFAULT_DIV(8'd3)
  ) dut (
    .clock_50MHZ(clock_50MHZ),
    .reset_n(reset_n),
    .enable(enable),
    .mode(mode),
    .sync_clear(sync_clear),
    .load_valid(load_valid),
    .load_ch(load_ch),
    .load_value(load_value),
    .clk_out(clk_out),
    .tick(tick)
  );

  initial begin
    clock_50MHZ = 1'b0;
    forever #10 clock_50MHZ = ~clock_50MHZ;
  end

  // DUT acts on the falling edge; the bench drives and samples on the rising edge.
  task automatic step();
    @(posedge clock_50MHZ);
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick[ch] !== 1'b1 && n < 40);
  endtask

  task automatic do_load(input logic [3:0] ch, input logic [WIDTH-1:0] val);
    load_valid = 1'b1;
    load_ch    = ch;
    load_value = val;
    step();
    load_valid = 1'b0;
  endtask

  task automatic check_interval(input string name, input int n);
    int e;
    e = exp_q.pop_front();
    total++;
    if (n !== e) begin
      bad++;
      $display("FAIL %s: interval=%0d expected=%0d", name, n, e);
    end
  endtask

  task automatic test_reset();
    int n;
    enable = 4'hF;
    mode   = 4'h0;
    step();
    step();
    total++;
    if (clk_out !== 4'h0 || tick !== 4'h0) begin
      bad++;
      $display("FAIL reset_state: clk_out=%h tick=%h expected 0/0", clk_out, tick);
    end
    reset_n = 1'b1;
    exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4);
    wait_tick(0, n);
    check_interval("reset_first_tick", n);
    total++;
    if (clk_out !== 4'hF || tick !== 4'hF) begin
      bad++;
      $display("FAIL reset_toggle_high: clk_out=%h tick=%h expected f/f", clk_out, tick);
    end
    wait_tick(0, n);
    check_interval("reset_second_tick", n);
    total++;
    if (clk_out !== 4'h0) begin
      bad++;
      $display("FAIL reset_toggle_low: clk_out=%h expected 0", clk_out);
    end
    wait_tick(0, n);
    check_interval("reset_third_tick", n);
    reset_n = 1'b0;
    #1;
    total++;
    if (clk_out !== 4'h0 || tick !== 4'h0) begin
      bad++;
      $display("FAIL reset_async: clk_out=%h tick=%h expected 0/0", clk_out, tick);
    end
    enable = 4'h0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_deferred_load();
    int n;
    enable = 4'b0010;
    exp_q.push_back(4);
    wait_tick(1, n);
    check_interval("defer_first", n);
    step();
    do_load(4'd1, 8'd5);
    exp_q.push_back(4); exp_q.push_back(6); exp_q.push_back(6);
    wait_tick(1, n);
    check_interval("defer_current_period", n + 2);
    wait_tick(1, n);
    check_interval("defer_new_period_a", n);
    wait_tick(1, n);
    check_interval("defer_new_period_b", n);
  endtask

  task automatic test_load_at_terminal();
    int n;
    for (int k = 0; k < 5; k++) step();
    load_valid = 1'b1;
    load_ch    = 4'd1;
    load_value = 8'd2;
    step();
    load_valid = 1'b0;
    total++;
    if (tick[1] !== 1'b1) begin
      bad++;
      $display("FAIL tc_load_old_period: tick1=%b expected 1", tick[1]);
    end
    exp_q.push_back(3); exp_q.push_back(3);
    wait_tick(1, n);
    check_interval("tc_load_next", n);
    wait_tick(1, n);
    check_interval("tc_load_after", n);
  endtask

  task automatic test_ignored_load();
    int n;
    do_load(4'd7, 8'd9);
    enable = 4'b1010;
    exp_q.push_back(4);
    wait_tick(3, n);
    check_interval("bad_ch_ch3", n);
    wait_tick(1, n);
    exp_q.push_back(3);
    wait_tick(1, n);
    check_interval("bad_ch_ch1", n);
  endtask

  task automatic test_pulse_div0();
    int n;
    mode = 4'b0100;
    do_load(4'd2, 8'd0);
    enable = enable | 4'b0100;
    exp_q.push_back(1);
    wait_tick(2, n);
    check_interval("div0_first", n);
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({tick[2], clk_out[2]} !== 2'b11) begin
        bad++;
        $display("FAIL div0_every_cycle: tick/clk=%b expected 11", {tick[2], clk_out[2]});
      end
    end
    enable[2] = 1'b0;
    step();
    total++;
    if ({tick[2], clk_out[2]} !== 2'b00) begin
      bad++;
      $display("FAIL div0_disable: tick/clk=%b expected 00", {tick[2], clk_out[2]});
    end
  endtask

  task automatic test_phase_align();
    int n;
    enable = 4'h0;
    mode   = 4'h0;
    step();
    do_load(4'd0, 8'd4);
    do_load(4'd2, 8'd4);
    enable[0] = 1'b1;
    step();
    step();
    enable[2] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(5);
      wait_tick(0, n);
      check_interval("align_interval", n);
      total++;
      if (tick[2] !== 1'b1) begin
        bad++;
        $display("FAIL align_coincide: tick2=%b expected 1", tick[2]);
      end
    end
  endtask

  task automatic test_reenable();
    int n;
    enable = 4'b1000;
    mode   = 4'h0;
    exp_q.push_back(4);
    wait_tick(3, n);
    check_interval("reen_start", n);
    total++;
    if (clk_out[3] !== 1'b1) begin
      bad++;
      $display("FAIL reen_clk_high: clk3=%b expected 1", clk_out[3]);
    end
    step();
    enable[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({tick[3], clk_out[3]} !== 2'b00) begin
        bad++;
        $display("FAIL reen_disabled: tick/clk=%b expected 00", {tick[3], clk_out[3]});
      end
    end
    enable[3] = 1'b1;
    exp_q.push_back(4);
    wait_tick(3, n);
    check_interval("reen_first_tick", n);
    total++;
    if (clk_out[3] !== 1'b1) begin
      bad++;
      $display("FAIL reen_clk_after: clk3=%b expected 1", clk_out[3]);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = '0;
    mode       = '0;
    sync_clear = 1'b0;
    load_valid = 1'b0;
    load_ch    = '0;
    load_value = '0;
    test_reset();
    test_deferred_load();
    test_load_at_terminal();
    test_ignored_load();
    test_pulse_div0();
    test_phase_align();
    test_reenable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised, multi-channel successor to the single fixed-ratio display clock divider. It divides the 50 MHz board clock into CHANNELS independent outputs, each with a runtime-programmable divisor, enable and output mode (square wave or one-cycle tick). Downstream blocks (display multiplexing, counters, debouncers) consume `clk_out` or `tick`. The divisor update path is glitch-free.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `WIDTH`, 26: divisor and counter width in bits.
- `DEFAULT_DIV`, 26'hC350: divisor loaded into every channel at reset.
- `clock_50MHZ`  in  1  system clock; all flops act on its falling edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  CHANNELS  per-channel run enable; bit i controls channel i.
- `mode`  in  CHANNELS  per-channel output mode: 0 = toggle (square wave), 1 = pulse.
- `sync_clear`  in  1  synchronous phase-align: restarts all channel counters together.
- `load_valid`  in  1  one-cycle strobe that writes a new divisor.
- `load_ch`  in  4  target channel index for the load.
- `load_value`  in  WIDTH  new divisor value.
- `clk_out`  out  CHANNELS  divided output per channel.
- `tick`  out  CHANNELS  one-cycle pulse at each terminal count.

## Operation
- Per-channel state: `counter[WIDTH]`, `active_div[WIDTH]`, `shadow_div[WIDTH]`, `clk_out` flop, `tick` flop.
- Reset (reset_n = 0, any time, asynchronous): counter = 0, clk_out = 0, tick = 0, active_div = shadow_div = DEFAULT_DIV. Reset mid-period discards the period. No partial pulse is produced.
- Counting (enable[i] = 1): counter increments by 1 per cycle until counter == active_div (the terminal count). On the terminal count, the next edge sets counter to 0, active_div to shadow_div, and tick[i] to 1 for exactly one cycle.
- Toggle mode: clk_out[i] inverts at each terminal count. Period is 2*(active_div+1) cycles with 50 % duty.
- Pulse mode: clk_out[i] equals tick[i] (registered, same cycle). Period is active_div+1 cycles.
- Divisor 0: counting continues. tick is high every cycle, and toggle mode gives clock/2.
- Load: when load_valid = 1 and load_ch < CHANNELS, shadow_div[load_ch] = load_value. A load_ch ≥ CHANNELS is ignored with no state change.
  - Enabled channel: the new divisor takes effect at the next terminal count, so the current period completes unchanged.
  - Disabled channel: both active_div and shadow_div are written immediately.
  - Load on the terminal-count cycle: load_value goes directly to active_div for the next period.
- Disable (enable[i] = 0): counter is held at 0, and clk_out[i] and tick[i] are forced to 0 on the next edge. On re-enable, counting restarts from 0. The first terminal count comes after active_div+1 cycles.
- sync_clear = 1: every counter goes to 0, clk_out goes to 0 and tick goes to 0 on the next edge. Divisors are kept. sync_clear has priority over terminal count and enable. A load in the same cycle still updates the divisors.
- Mode change mid-period: takes effect on the next edge. clk_out is re-driven per the new mode, and the counter is not disturbed.
- Channels are fully independent except for the shared sync_clear and load bus.

## Timing
- All registers use the falling edge of clock_50MHZ. Outputs are registered with no combinational path from inputs.
- Latency from enable rising to the first tick: active_div+1 cycles.
- Load-to-effect latency on an enabled channel: 1 to active_div+1 cycles (next terminal count).
- Counter wrap is explicit at active_div. The counter never reaches 2^WIDTH−1 unless active_div = 2^WIDTH−1.
- The terminal compare uses the registered active_div. Priority is reset_n > sync_clear > !enable > terminal count > increment.

## Test plan
- Reset behaviour (WIDTH = 8, DEFAULT_DIV = 3): release reset_n with all channels enabled in toggle mode. Required: clk_out period of 8 cycles and tick every 4 cycles. Assert reset_n mid-period; clk_out and tick must go to 0 immediately.
- Deferred load: channel 1 enabled, active_div = 3. Load 5 at counter = 1. Required: the current period ends at count 3, and the next tick interval is 6 cycles.
- Simultaneous load and terminal count: load 2 on the cycle counter == active_div. Required: the very next interval is 3 cycles. Separately, load_ch = 7 with CHANNELS = 4 must leave all divisors unchanged.
- Pulse mode with divisor 0: mode = 1, load 0 while disabled, then enable. Required: tick = clk_out = 1 every cycle. Disable; both must be 0 on the next edge.
- Phase alignment: channels 0 and 2 with divisor 4, started at different times. Pulse sync_clear. Required: their ticks then coincide every 5 cycles, and divisors are unchanged.
- Re-enable: disable channel 3 mid-period with clk_out = 1. Required: clk_out goes to 0 and counter holds 0. Re-enable; the first tick comes exactly active_div+1 cycles later.
